mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for the pipelined MIPS core; owns the HI/LO registers.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO per start from the execute stage.
- Holds busy for a fixed latency, then commits HI/LO.
- Raises md_stall so decode holds any HI/LO-touching instruction while an operation is in flight.

---
 rtl/mdu_ctrl_pkg.sv | 39 +++
 rtl/mdu_ctrl_arith.sv | 131 +++++++++++++
 rtl/mdu_ctrl.sv | 132 +++++++++++++
 tb/tb_mdu_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared definitions for the multiply/divide sequencer.
// Op encodings (MD_*), FSM state type and the operation-class type that the
// arithmetic block reports back to the controller.
// Optional feature macro: MDU_MADD_EN (widens op to 4 bits, adds MADD/MSUB).
package mdu_ctrl_pkg;

`ifdef MDU_MADD_EN
  localparam int OP_W = 4;
`else
  localparam int OP_W = 3;
`endif

  localparam logic [OP_W-1:0] MD_MULT  = OP_W'(0);
  localparam logic [OP_W-1:0] MD_MULTU = OP_W'(1);
  localparam logic [OP_W-1:0] MD_DIV   = OP_W'(2);
  localparam logic [OP_W-1:0] MD_DIVU  = OP_W'(3);
  localparam logic [OP_W-1:0] MD_MTHI  = OP_W'(4);
  localparam logic [OP_W-1:0] MD_MTLO  = OP_W'(5);
`ifdef MDU_MADD_EN
  localparam logic [OP_W-1:0] MD_MADD  = OP_W'(6);
  localparam logic [OP_W-1:0] MD_MADDU = OP_W'(7);
  localparam logic [OP_W-1:0] MD_MSUB  = OP_W'(8);
  localparam logic [OP_W-1:0] MD_MSUBU = OP_W'(9);
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // Operation class: K_MUL/K_DIV start a timed run, K_MT writes HI/LO at once.
  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_MUL  = 2'd1,
    K_DIV  = 2'd2,
    K_MT   = 2'd3
  } md_kind_t;

endpackage

// File: rtl/mdu_ctrl_arith.sv
// mdu_arith: purely combinational result generator.
// Ports:
//   i_op            operation code (MD_*)
//   i_a, i_b        rs / rt operands
//   i_hi, i_lo      current HI/LO (accumulator base, untouched half for MTHI/MTLO)
//   o_pend_hi/lo    value HI/LO will take when the operation commits
//   o_wr_en         1 if the commit should actually write HI/LO (0 on divide by zero)
//   o_kind          operation class; K_NONE for undefined op codes
// Optional feature macro: MDU_MADD_EN (multiply-accumulate/subtract ops).
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic [31:0]     i_a,
  input  logic [31:0]     i_b,
  input  logic [31:0]     i_hi,
  input  logic [31:0]     i_lo,
  output logic [31:0]     o_pend_hi,
  output logic [31:0]     o_pend_lo,
  output logic            o_wr_en,
  output md_kind_t        o_kind
);

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic        w_div0;
  logic [31:0] w_dvs;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_squot;
  logic [31:0] w_srem;
  logic [31:0] w_uquot;
  logic [31:0] w_urem;
`ifdef MDU_MADD_EN
  logic [63:0] w_acc;
`endif

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply
  // equal to the signed product.
  assign w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  // Divisor forced to 1 on zero so the dividers never see x; wr_en blocks commit.
  assign w_div0 = (i_b == 32'd0);
  assign w_dvs  = w_div0 ? 32'd1 : i_b;

  assign w_uquot = i_a / w_dvs;
  assign w_urem  = i_a % w_dvs;

  // Signed divide on magnitudes. 0x80000000 negates to itself, which yields
  // quotient 0x80000000 / remainder 0 for 0x80000000 / -1 without a special case.
  assign w_abs_a = i_a[31]   ? -i_a   : i_a;
  assign w_abs_b = w_dvs[31] ? -w_dvs : w_dvs;
  assign w_sq    = w_abs_a / w_abs_b;
  assign w_sr    = w_abs_a % w_abs_b;
  assign w_squot = (i_a[31] ^ w_dvs[31]) ? -w_sq : w_sq;
  assign w_srem  = i_a[31] ? -w_sr : w_sr;

`ifdef MDU_MADD_EN
  assign w_acc = {i_hi, i_lo};
`endif

  always_comb begin
    o_pend_hi = i_hi;
    o_pend_lo = i_lo;
    o_wr_en   = 1'b0;
    o_kind    = K_NONE;
    case (i_op)
      MD_MULT: begin
        {o_pend_hi, o_pend_lo} = w_sprod;
        o_wr_en = 1'b1;
        o_kind  = K_MUL;
      end
      MD_MULTU: begin
        {o_pend_hi, o_pend_lo} = w_uprod;
        o_wr_en = 1'b1;
        o_kind  = K_MUL;
      end
      MD_DIV: begin
        o_pend_hi = w_srem;
        o_pend_lo = w_squot;
        o_wr_en   = ~w_div0;
        o_kind    = K_DIV;
      end
      MD_DIVU: begin
        o_pend_hi = w_urem;
        o_pend_lo = w_uquot;
        o_wr_en   = ~w_div0;
        o_kind    = K_DIV;
      end
      MD_MTHI: begin
        o_pend_hi = i_a;
        o_wr_en   = 1'b1;
        o_kind    = K_MT;
      end
      MD_MTLO: begin
        o_pend_lo = i_a;
        o_wr_en   = 1'b1;
        o_kind    = K_MT;
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        {o_pend_hi, o_pend_lo} = w_acc + w_sprod;
        o_wr_en = 1'b1;
        o_kind  = K_MUL;
      end
      MD_MADDU: begin
        {o_pend_hi, o_pend_lo} = w_acc + w_uprod;
        o_wr_en = 1'b1;
        o_kind  = K_MUL;
      end
      MD_MSUB: begin
        {o_pend_hi, o_pend_lo} = w_acc - w_sprod;
        o_wr_en = 1'b1;
        o_kind  = K_MUL;
      end
      MD_MSUBU: begin
        {o_pend_hi, o_pend_lo} = w_acc - w_uprod;
        o_wr_en = 1'b1;
        o_kind  = K_MUL;
      end
`endif
      default: begin
        o_kind = K_NONE;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer owning HI/LO.
// Ports:
//   clk        core clock, rising edge
//   reset      asynchronous active-low reset
//   start      execute stage issues an MD op this cycle
//   op         operation code (MD_*)
//   a, b       rs / rt operands
//   d_is_md    decode-stage instruction touches the MDU
//   hi, lo     HI / LO registers
//   busy       operation in flight
//   done       one-cycle pulse on mult/div completion
//   md_stall   stall request to hazard logic (combinational)
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepts a new op; MTHI/MTLO write HI/LO on the start edge
// ST_RUN  | timed mult/div in flight, result held in pend_hi/pend_lo
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  input  logic            d_is_md,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic            busy,
  output logic            done,
  output logic            md_stall
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]    r_hi;
  logic [31:0]    r_lo;
  logic [31:0]    r_pend_hi;
  logic [31:0]    r_pend_lo;
  logic           r_pend_wr;
  logic           r_busy;
  logic           r_done;

  logic [31:0]    w_pend_hi;
  logic [31:0]    w_pend_lo;
  logic           w_wr_en;
  md_kind_t       w_kind;

  mdu_arith u_arith (
    .i_op      (op),
    .i_a       (a),
    .i_b       (b),
    .i_hi      (r_hi),
    .i_lo      (r_lo),
    .o_pend_hi (w_pend_hi),
    .o_pend_lo (w_pend_lo),
    .o_wr_en   (w_wr_en),
    .o_kind    (w_kind)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (w_kind)
              K_MUL, K_DIV: begin
                r_pend_hi <= w_pend_hi;
                r_pend_lo <= w_pend_lo;
                r_pend_wr <= w_wr_en;
                r_cnt     <= (w_kind == K_DIV) ? CNT_W'(DIV_CYCLES - 1)
                                               : CNT_W'(MULT_CYCLES - 1);
                r_busy    <= 1'b1;
                r_state   <= ST_RUN;
              end
              K_MT: begin
                r_hi <= w_pend_hi;
                r_lo <= w_pend_lo;
              end
              default: begin
              end
            endcase
          end
        end
        ST_RUN: begin
          // start is deliberately not looked at here; a second issue is ignored.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  // Includes start so the issuing cycle is already covered before busy rises.
  assign md_stall = d_is_md & (r_busy | start);

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [OP_W-1:0] op;
  logic [31:0]     a;
  logic [31:0]     b;
  logic            d_is_md;
  logic [31:0]     hi;
  logic [31:0]     lo;
  logic            busy;
  logic            done;
  logic            md_stall;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .d_is_md  (d_is_md),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .md_stall (md_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input logic [OP_W-1:0] o);
    return (o == MD_DIV || o == MD_DIVU) ? 10 : 5;
  endfunction

  // Reference model: plain 64-bit integer arithmetic on the architectural HI/LO.
  task automatic model_apply(input logic [OP_W-1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy, acc, r;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    acc = {m_hi, m_lo};
    r   = acc;
    case (o)
      MD_MULT:  r = longint'(sx * sy);
      MD_MULTU: r = ux * uy;
      MD_DIV:   if (y != 0) r = {32'(sx % sy), 32'(sx / sy)};
      MD_DIVU:  if (y != 0) r = {32'(ux % uy), 32'(ux / uy)};
      MD_MTHI:  r = {x, m_lo};
      MD_MTLO:  r = {m_hi, x};
`ifdef MDU_MADD_EN
      MD_MADD:  r = acc + longint'(sx * sy);
      MD_MADDU: r = acc + ux * uy;
      MD_MSUB:  r = acc - longint'(sx * sy);
      MD_MSUBU: r = acc - ux * uy;
`endif
      default:  r = acc;
    endcase
    m_hi = r[63:32];
    m_lo = r[31:0];
  endtask

  // Timed mult/div; intrude>0 re-issues start on that busy cycle.
  task automatic run_op(input logic [OP_W-1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic dmd, input int intrude);
    int n;
    model_apply(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1; d_is_md = dmd;
    #1 chk("stall_start", md_stall, dmd);
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == intrude) begin
        start = 1'b1; op = MD_MTHI; a = $urandom;
      end else begin
        start = 1'b0;
      end
      #1 chk("stall_busy", md_stall, dmd);
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    chk("busy_len", n, lat(o));
    chk("done_hi", done, 1'b1);
    chk("res_hi", hi, m_hi);
    chk("res_lo", lo, m_lo);
    chk("stall_after", md_stall, 1'b0);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    d_is_md = 1'b0;
  endtask

  // Single-edge ops (MTHI/MTLO/undefined): no busy, no done.
  task automatic run_mt(input logic [OP_W-1:0] o, input logic [31:0] x);
    model_apply(o, x, 32'd0);
    @(negedge clk);
    op = o; a = x; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
    chk("mt_busy", busy, 1'b0);
    chk("mt_done", done, 1'b0);
  endtask

  logic [OP_W-1:0] ops[$];
  logic [OP_W-1:0] undef_op;
  logic [OP_W-1:0] ro;
  logic [31:0]     rb;
  logic            saw_done;

  initial begin
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
`ifdef MDU_MADD_EN
    ops.push_back(MD_MADD);
    ops.push_back(MD_MADDU);
    ops.push_back(MD_MSUB);
    ops.push_back(MD_MSUBU);
    undef_op = OP_W'(15);
`else
    undef_op = OP_W'(6);
`endif

    // Reset held with start asserted.
    reset = 1'b0; start = 1'b1; op = MD_MULT; a = 32'd5; b = 32'd7; d_is_md = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_hi", hi, 32'd0);

    // Directed arithmetic.
    run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    run_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, 0);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 3);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);
    run_op(MD_DIVU, 32'd7, 32'd2, 1'b0, 0);
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);

    // Boundaries.
    run_mt(MD_MTHI, 32'h11);
    run_mt(MD_MTLO, 32'h22);
    run_op(MD_DIV, 32'h12345678, 32'd0, 1'b1, 0);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 9);
    chk("ovf_hi", hi, 32'd0);
    chk("ovf_lo", lo, 32'h80000000);
    run_mt(MD_MTHI, 32'h1234);
    chk("mthi_hi", hi, 32'h1234);
    run_mt(undef_op, 32'hDEADBEEF);

    // Reset in busy cycle 4 of a DIV.
    @(negedge clk);
    op = MD_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("midrst_quiet", saw_done, 1'b0);
    chk("midrst_lo2", lo, 32'd0);

`ifdef MDU_MADD_EN
    run_mt(MD_MTHI, 32'd0);
    run_mt(MD_MTLO, 32'hFFFFFFFF);
    run_op(MD_MADDU, 32'd1, 32'd1, 1'b1, 0);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
`endif

    // Randomized ops against the model.
    for (int i = 0; i < 30; i++) begin
      ro = ops[$urandom_range(0, ops.size() - 1)];
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if (ro == MD_MTHI || ro == MD_MTLO)
        run_mt(ro, $urandom);
      else
        run_op(ro, $urandom, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
